mask_distr_n: RTL and testbench
===============================

MASK_DISTR_N -- requirements
Module: mask_distr_n

Interface
REQ-001 Parameter DATA_WIDTH, default 24, pixel width; SHALL be a multiple of 3 (R msb, G, B lsb; CW = DATA_WIDTH/3).
REQ-002 Parameter N_LANES, default 4, number of mask lanes; SHALL be a power of 2, range 2..8.
REQ-003 Parameter FIFO_DEPTH, default 4, per-lane reorder FIFO depth, range 2..16.
REQ-004 Parameter ROW_PIXELS, default 640, mask pixels per row.
REQ-005 Parameter ROWS_PER_FLAG, default 12, rows per o_FULL_ROWS pulse.
REQ-006 i_CLK  in  1  single clock; all logic on its rising edge.
REQ-007 i_RSTn  in  1  reset; asynchronous, active-low.
REQ-008 i_DATA  in  DATA_WIDTH  RGB pixel.
REQ-009 i_DATA_VALID  in  1  pixel valid.
REQ-010 o_READY  out  1  pixel accepted when i_DATA_VALID and o_READY both high.
REQ-011 i_THRESHOLD  in  CW  mask threshold T.
REQ-012 o_MASK  out  1  mask bit, 1 = foreground.
REQ-013 o_MASK_VALID  out  1  o_MASK valid.
REQ-014 i_MASK_READY  in  1  downstream ready; transfer when o_MASK_VALID and i_MASK_READY both high.
REQ-015 o_ROW_CNT  out  clog2(ROWS_PER_FLAG)  completed rows in current group.
REQ-016 o_FULL_ROWS  out  1  one-cycle pulse when ROWS_PER_FLAG rows are complete.

Function
REQ-017 Distributor: wr_lane pointer SHALL advance by 1 on each accepted pixel, wrapping N_LANES-1 -> 0.
- Pixel and i_THRESHOLD SHALL be captured together, so a T change applies from the next accepted pixel.
REQ-018 Each lane SHALL be a 2-stage pipeline.
- Stage 1: register R, G, B, T.
- Stage 2: mask = (G > R + T) AND (G > B + T), sums computed at CW+1 bits with no overflow wrap; result written to the lane FIFO.
REQ-019 Credit per lane = in-pipeline entries + FIFO occupancy, range 0..FIFO_DEPTH.
- o_READY = (credit[wr_lane] < FIFO_DEPTH).
- Accept and pop on the same lane in the same cycle SHALL leave that lane's credit unchanged.
REQ-020 Collector: rd_lane pointer. Output register loads the head of FIFO[rd_lane] when that FIFO is non-empty and (o_MASK_VALID = 0 or i_MASK_READY = 1).
- rd_lane advances on each pop, wrapping N_LANES-1 -> 0, so output order equals input order.
REQ-021 If o_MASK_VALID = 1 and i_MASK_READY = 0, o_MASK and o_MASK_VALID SHALL hold stable.
REQ-022 Latency: with all lanes empty and i_MASK_READY = 1, o_MASK_VALID SHALL rise exactly 3 rising edges after the accepting edge.
- Sustained throughput SHALL be 1 pixel/cycle.
REQ-023 Rows: a pixel counter SHALL count mask transfers.
- At ROW_PIXELS transfers: pixel counter -> 0, o_ROW_CNT += 1.
- When the completing row makes the total ROWS_PER_FLAG: o_FULL_ROWS SHALL pulse high for the next cycle and o_ROW_CNT -> 0.
REQ-024 No pixel SHALL be dropped or duplicated under any pattern of i_DATA_VALID or i_MASK_READY.
REQ-025 If one FIFO is full while other lanes have space, o_READY SHALL still follow only credit[wr_lane]; lanes are never skipped.

Reset
REQ-026 While i_RSTn = 0, asynchronously:
- wr_lane, rd_lane, all credits, FIFOs and pipeline valids -> 0.
- o_MASK = 0, o_MASK_VALID = 0, o_ROW_CNT = 0, o_FULL_ROWS = 0.
- o_READY = 0.
REQ-027 o_READY SHALL go to 1 on the first clock edge after i_RSTn deasserts.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight pixels; no mask from before the reset SHALL appear after it.

Verification
REQ-029 Single pixel 0x10F010, T = 0x20, N_LANES = 4 -> o_MASK = 1, o_MASK_VALID high exactly 3 edges after acceptance. Pixel 0x10F010 with T = 0xE0 -> o_MASK = 0.
REQ-030 Boundary: G = 0xFF, R = B = 0xFF, T = 0; then G = 0xFF, R = 0x00, T = 0xFF -> both o_MASK = 0 (no overflow wrap).
REQ-031 1000 random pixels, valid 70%, i_MASK_READY 50% random -> mask stream equals the golden model bit-for-bit and in order; o_MASK stable during stalls.
REQ-032 i_MASK_READY = 0 continuously with 32 pixels offered (N_LANES = 4, FIFO_DEPTH = 4) -> exactly 17 accepted (16 in lane storage + 1 in output register), o_READY low thereafter; release -> 17 masks emitted in order.
REQ-033 ROW_PIXELS = 8, ROWS_PER_FLAG = 3, 48 pixels -> o_FULL_ROWS pulses exactly twice, after transfers 24 and 48; o_ROW_CNT sequence 0,1,2,0,1,2,0.
REQ-034 Reset asserted after 10 accepted pixels, 5 emitted -> all outputs 0 immediately; after release, a new pixel appears with 3-cycle latency and no stale masks are emitted.

Source files
------------

// File: rtl/mask_distr_n.sv
// Foreground mask engine: round-robin distribution of RGB pixels over N_LANES
// two-stage compare pipelines, per-lane reorder FIFOs and an in-order collector.
module mask_distr_n #(
  parameter int DATA_WIDTH    = 24,
  parameter int N_LANES       = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROW_PIXELS    = 640,
  parameter int ROWS_PER_FLAG = 12,
  localparam int CW           = DATA_WIDTH / 3,
  localparam int RCW          = (ROWS_PER_FLAG > 1) ? $clog2(ROWS_PER_FLAG) : 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_DATA_VALID,
  output logic                  o_READY,
  input  logic [CW-1:0]         i_THRESHOLD,
  output logic                  o_MASK,
  output logic                  o_MASK_VALID,
  input  logic                  i_MASK_READY,
  output logic [RCW-1:0]        o_ROW_CNT,
  output logic                  o_FULL_ROWS
);
  localparam int LW   = $clog2(N_LANES);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int PXW  = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;

  logic                  r_run;
  logic [LW-1:0]         r_wr_lane;
  logic [LW-1:0]         r_rd_lane;
  logic [CNTW-1:0]       r_credit [N_LANES];
  logic [N_LANES-1:0]    r_s1_vld;
  logic [CW-1:0]         r_s1_r   [N_LANES];
  logic [CW-1:0]         r_s1_g   [N_LANES];
  logic [CW-1:0]         r_s1_b   [N_LANES];
  logic [CW-1:0]         r_s1_t   [N_LANES];
  logic [N_LANES-1:0]    r_s2_vld;
  logic [N_LANES-1:0]    r_s2_mask;
  logic [FIFO_DEPTH-1:0] r_fifo   [N_LANES];
  logic [PW-1:0]         r_fwr    [N_LANES];
  logic [PW-1:0]         r_frd    [N_LANES];
  logic [CNTW-1:0]       r_fcnt   [N_LANES];
  logic                  r_mask;
  logic                  r_mask_vld;
  logic [PXW-1:0]        r_pix_cnt;
  logic [RCW-1:0]        r_row_cnt;
  logic                  r_full;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_xfer;
  logic [N_LANES-1:0]    w_acc_lane;
  logic [N_LANES-1:0]    w_pop_lane;
  logic [N_LANES-1:0]    w_cmp;

  // r_run keeps o_READY low during reset and for no longer than one edge after it
  assign o_READY      = r_run && (r_credit[r_wr_lane] < CNTW'(FIFO_DEPTH));
  assign w_accept     = i_DATA_VALID && o_READY;
  assign w_pop        = (r_fcnt[r_rd_lane] != '0) && (!r_mask_vld || i_MASK_READY);
  assign w_xfer       = r_mask_vld && i_MASK_READY;
  assign o_MASK       = r_mask;
  assign o_MASK_VALID = r_mask_vld;
  assign o_ROW_CNT    = r_row_cnt;
  assign o_FULL_ROWS  = r_full;

  // Sums are one bit wider than a channel so R+T and B+T never wrap
  always_comb begin
    w_acc_lane = '0;
    w_pop_lane = '0;
    w_cmp      = '0;
    for (int l = 0; l < N_LANES; l++) begin
      w_acc_lane[l] = w_accept && (r_wr_lane == LW'(l));
      w_pop_lane[l] = w_pop && (r_rd_lane == LW'(l));
      w_cmp[l] = ({1'b0, r_s1_g[l]} > ({1'b0, r_s1_r[l]} + {1'b0, r_s1_t[l]})) &&
                 ({1'b0, r_s1_g[l]} > ({1'b0, r_s1_b[l]} + {1'b0, r_s1_t[l]}));
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_s1_vld  <= '0;
      r_s2_vld  <= '0;
      r_s2_mask <= '0;
      for (int l = 0; l < N_LANES; l++) begin
        r_credit[l] <= '0;
        r_s1_r[l]   <= '0;
        r_s1_g[l]   <= '0;
        r_s1_b[l]   <= '0;
        r_s1_t[l]   <= '0;
        r_fifo[l]   <= '0;
        r_fwr[l]    <= '0;
        r_frd[l]    <= '0;
        r_fcnt[l]   <= '0;
      end
    end else begin
      r_s1_vld  <= w_acc_lane;
      r_s2_vld  <= r_s1_vld;
      r_s2_mask <= w_cmp;
      for (int l = 0; l < N_LANES; l++) begin
        if (w_acc_lane[l]) begin
          r_s1_r[l] <= i_DATA[3*CW-1 -: CW];
          r_s1_g[l] <= i_DATA[2*CW-1 -: CW];
          r_s1_b[l] <= i_DATA[CW-1:0];
          r_s1_t[l] <= i_THRESHOLD;
        end
        // Credit reserves FIFO space at acceptance, so the pipeline never stalls
        if (w_acc_lane[l] && !w_pop_lane[l])
          r_credit[l] <= r_credit[l] + CNTW'(1);
        else if (!w_acc_lane[l] && w_pop_lane[l])
          r_credit[l] <= r_credit[l] - CNTW'(1);
        if (r_s2_vld[l]) begin
          r_fifo[l][r_fwr[l]] <= r_s2_mask[l];
          r_fwr[l] <= (r_fwr[l] == PW'(FIFO_DEPTH - 1)) ? '0 : r_fwr[l] + PW'(1);
        end
        if (w_pop_lane[l])
          r_frd[l] <= (r_frd[l] == PW'(FIFO_DEPTH - 1)) ? '0 : r_frd[l] + PW'(1);
        if (r_s2_vld[l] && !w_pop_lane[l])
          r_fcnt[l] <= r_fcnt[l] + CNTW'(1);
        else if (!r_s2_vld[l] && w_pop_lane[l])
          r_fcnt[l] <= r_fcnt[l] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_run      <= 1'b0;
      r_wr_lane  <= '0;
      r_rd_lane  <= '0;
      r_mask     <= 1'b0;
      r_mask_vld <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept)
        r_wr_lane <= r_wr_lane + LW'(1);
      if (w_pop) begin
        r_mask     <= r_fifo[r_rd_lane][r_frd[r_rd_lane]];
        r_mask_vld <= 1'b1;
        r_rd_lane  <= r_rd_lane + LW'(1);
      end else if (w_xfer) begin
        r_mask_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_pix_cnt <= '0;
      r_row_cnt <= '0;
      r_full    <= 1'b0;
    end else begin
      r_full <= 1'b0;
      if (w_xfer) begin
        if (r_pix_cnt == PXW'(ROW_PIXELS - 1)) begin
          r_pix_cnt <= '0;
          if (r_row_cnt == RCW'(ROWS_PER_FLAG - 1)) begin
            r_row_cnt <= '0;
            r_full    <= 1'b1;
          end else begin
            r_row_cnt <= r_row_cnt + RCW'(1);
          end
        end else begin
          r_pix_cnt <= r_pix_cnt + PXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_distr_n.sv
// Directed bench for mask_distr_n: reset, latency, overflow boundaries, rows,
// backpressure capacity, random stream against a reference mask function, mid-stream reset.
module tb_mask_distr_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data;
  logic        dvalid;
  logic        ready;
  logic [7:0]  thr;
  logic        mask;
  logic        mvalid;
  logic        mready;
  logic [1:0]  row_cnt;
  logic        full;

  int   checks = 0;
  int   failures = 0;
  logic obs_q[$];
  logic exp_q[$];
  int   full_at[$];
  int   rc_q[$];
  logic prev_stall = 1'b0;
  logic prev_mask = 1'b0;
  logic [1:0] prev_rc = 2'd0;
  int   exp_rc [6] = '{1, 2, 0, 1, 2, 0};

  always #5 clk = ~clk;

  mask_distr_n #(
    .DATA_WIDTH(24), .N_LANES(4), .FIFO_DEPTH(4), .ROW_PIXELS(8), .ROWS_PER_FLAG(3)
  ) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_DATA(data), .i_DATA_VALID(dvalid), .o_READY(ready),
    .i_THRESHOLD(thr), .o_MASK(mask), .o_MASK_VALID(mvalid), .i_MASK_READY(mready),
    .o_ROW_CNT(row_cnt), .o_FULL_ROWS(full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model(input logic [23:0] px, input logic [7:0] t);
    int r, g, b, ti;
    r  = int'(px[23:16]);
    g  = int'(px[15:8]);
    b  = int'(px[7:0]);
    ti = int'(t);
    return (g > r + ti) && (g > b + ti);
  endfunction

  task automatic latency_test(input string tag, input logic [23:0] px, input logic [7:0] t,
                              input logic exp);
    data = px; thr = t; dvalid = 1'b1;
    check({tag, "_ready"}, 32'(ready), 1);
    step;
    dvalid = 1'b0;
    step; check({tag, "_e1_valid"}, 32'(mvalid), 0);
    step; check({tag, "_e2_valid"}, 32'(mvalid), 0);
    step; check({tag, "_e3_valid"}, 32'(mvalid), 1);
    check({tag, "_mask"}, 32'(mask), 32'(exp));
    step; step;
  endtask

  // Transfer log, row/flag log and hold-while-stalled check
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_rc    <= 2'd0;
    end else begin
      if (prev_stall)
        check("stall_hold", {30'd0, mvalid, mask}, {30'd0, 1'b1, prev_mask});
      if (full)
        full_at.push_back(obs_q.size());
      if (row_cnt != prev_rc) begin
        rc_q.push_back(int'(row_cnt));
        prev_rc <= row_cnt;
      end
      if (mvalid && mready)
        obs_q.push_back(mask);
      prev_stall <= mvalid && !mready;
      prev_mask  <= mask;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, cyc, nbad, first_bad;
    logic acc;
    dvalid = 1'b0; data = '0; thr = '0; mready = 1'b1;
    #2;
    check("rst_ready", 32'(ready), 0);
    check("rst_mvalid", 32'(mvalid), 0);
    check("rst_mask", 32'(mask), 0);
    check("rst_row_cnt", 32'(row_cnt), 0);
    check("rst_full", 32'(full), 0);
    step; step;
    check("rst_ready_held", 32'(ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 32'(ready), 0);
    step;
    check("ready_after_edge", 32'(ready), 1);

    // Rows: 48 pixels at full rate, 8 per row, flag every 3 rows
    obs_q.delete(); full_at.delete(); rc_q.delete();
    thr = 8'h20; k = 0; cyc = 0;
    while (k < 48 && cyc < 200) begin
      data = (k % 2 == 0) ? 24'h10F010 : 24'h808080;
      dvalid = 1'b1;
      acc = ready;
      step; cyc++;
      if (acc) k++;
    end
    dvalid = 1'b0;
    check("row_accepted", 32'(k), 48);
    check("row_throughput_cycles", 32'(cyc), 48);
    cyc = 0;
    while (obs_q.size() < 48 && cyc < 100) begin step; cyc++; end
    step; step;
    check("row_emitted", 32'(obs_q.size()), 48);
    nbad = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i] !== ((i % 2) == 0)) nbad++;
    check("row_mask_errors", 32'(nbad), 0);
    check("row_full_pulses", 32'(full_at.size()), 2);
    if (full_at.size() >= 2) begin
      check("row_full_at_1", 32'(full_at[0]), 24);
      check("row_full_at_2", 32'(full_at[1]), 48);
    end
    check("row_cnt_changes", 32'(rc_q.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < rc_q.size()) check($sformatf("row_cnt_seq_%0d", i), 32'(rc_q[i]), 32'(exp_rc[i]));
    check("row_cnt_final", 32'(row_cnt), 0);

    // Latency and no-wrap boundaries
    latency_test("lat_fg", 24'h10F010, 8'h20, 1'b1);
    latency_test("lat_high_t", 24'h10F010, 8'hE0, 1'b0);
    latency_test("ovf_all_ff", 24'hFFFFFF, 8'h00, 1'b0);
    latency_test("ovf_t_ff", 24'h00FF00, 8'hFF, 1'b0);

    // Backpressure: capacity is 4 lanes x 4 credits plus the output register
    obs_q.delete(); mready = 1'b0; thr = 8'h20; k = 0;
    for (int c = 0; c < 40; c++) begin
      data = (k % 3 == 0) ? 24'h10F010 : 24'h808080;
      dvalid = 1'b1;
      acc = ready;
      step;
      if (acc) k++;
    end
    dvalid = 1'b0;
    check("bp_accepted", 32'(k), 17);
    check("bp_ready_low", 32'(ready), 0);
    check("bp_out_valid", 32'(mvalid), 1);
    check("bp_none_emitted", 32'(obs_q.size()), 0);
    mready = 1'b1; cyc = 0;
    while (obs_q.size() < 17 && cyc < 100) begin step; cyc++; end
    repeat (5) step;
    check("bp_emitted", 32'(obs_q.size()), 17);
    for (int i = 0; i < 17; i++)
      if (i < obs_q.size()) check($sformatf("bp_mask_%0d", i), 32'(obs_q[i]), 32'((i % 3) == 0));

    // Random stream with random valid and downstream stalls
    obs_q.delete(); exp_q.delete(); k = 0; cyc = 0;
    while (k < 1000 && cyc < 6000) begin
      dvalid = ($urandom_range(0, 99) < 70);
      data   = 24'($urandom());
      thr    = 8'($urandom_range(0, 63));
      mready = 1'($urandom_range(0, 1));
      if (dvalid && ready) begin
        exp_q.push_back(model(data, thr));
        k++;
      end
      step; cyc++;
    end
    dvalid = 1'b0; mready = 1'b1;
    check("rand_accepted", 32'(k), 1000);
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < 200) begin step; cyc++; end
    repeat (5) step;
    check("rand_emitted", 32'(obs_q.size()), 32'(exp_q.size()));
    nbad = 0; first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
    check("rand_stream_errors", 32'(nbad), 0);

    // Mid-stream reset after 10 accepted and 5 emitted
    obs_q.delete(); mready = 1'b0; thr = 8'h20; k = 0; cyc = 0;
    while (k < 10 && cyc < 50) begin
      data = (k % 2 == 0) ? 24'h10F010 : 24'h808080;
      dvalid = 1'b1;
      acc = ready;
      step; cyc++;
      if (acc) k++;
    end
    dvalid = 1'b0;
    check("mid_rst_accepted", 32'(k), 10);
    mready = 1'b1; cyc = 0;
    while (obs_q.size() < 5 && cyc < 50) begin step; cyc++; end
    mready = 1'b0;
    check("mid_rst_emitted", 32'(obs_q.size()), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_mvalid", 32'(mvalid), 0);
    check("mid_rst_mask", 32'(mask), 0);
    check("mid_rst_row_cnt", 32'(row_cnt), 0);
    check("mid_rst_full", 32'(full), 0);
    step; step;
    rst_n = 1'b1;
    obs_q.delete();
    mready = 1'b1;
    step;
    check("post_rst_ready", 32'(ready), 1);
    latency_test("post_rst", 24'h10F010, 8'h20, 1'b1);
    repeat (20) step;
    check("post_rst_no_stale", 32'(obs_q.size()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
